// File: rtl/fixcomplex_mandeliter.sv
// Escape-time Mandelbrot engine: iterates z <- z*z + c from z = 0 until |z|^2 >= 4.0
// or the iteration cap, then holds {iter, escaped, z} until the consumer accepts it.
module fixcomplex_mandeliter #(
    parameter int ws    = 16,
    parameter int dp    = 8,
    parameter int iw    = 8,
    parameter int maxit = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*ws-1:0] c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [iw-1:0]   iter,
    output logic            escaped,
    output logic [2*ws-1:0] z_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [iw-1:0]   MAXN    = iw'(maxit);
    localparam logic [2*ws:0]   ESC_LIM = (2*ws+1)'(4) << (2*dp);

    state_t                 state_q, state_d;
    logic [2*ws-1:0]        c_q, c_d;
    logic signed [ws-1:0]   zr_q, zr_d, zi_q, zi_d;
    logic [iw-1:0]          n_q, n_d;
    logic [iw-1:0]          iter_q, iter_d;
    logic                   esc_q, esc_d;
    logic [2*ws-1:0]        zo_q, zo_d;

    // Full-width signed products; the escape test uses them untruncated.
    logic signed [2*ws-1:0] re_x, im_x, p_rr, p_ii, p_ri;
    logic [2*ws:0]          mag;
    logic signed [ws-1:0]   rr, ii, ri, c_re, c_im;
    logic                   esc_hit;

    always_comb begin
        re_x    = (2*ws)'(zr_q);
        im_x    = (2*ws)'(zi_q);
        p_rr    = re_x * re_x;
        p_ii    = im_x * im_x;
        p_ri    = re_x * im_x;
        rr      = p_rr[dp+ws-1:dp];
        ii      = p_ii[dp+ws-1:dp];
        ri      = p_ri[dp+ws-1:dp];
        mag     = {1'b0, p_rr} + {1'b0, p_ii};
        esc_hit = (mag >= ESC_LIM);
        c_re    = c_q[ws-1:0];
        c_im    = c_q[2*ws-1:ws];
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        n_d     = n_q;
        iter_d  = iter_q;
        esc_d   = esc_q;
        zo_d    = zo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d     = c;
                    zr_d    = '0;
                    zi_d    = '0;
                    n_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (esc_hit || n_q == MAXN) begin
                    esc_d   = esc_hit;
                    iter_d  = n_q;
                    zo_d    = {zi_q, zr_q};
                    state_d = DONE;
                end else begin
                    zr_d = rr - ii + c_re;
                    zi_d = ri + ri + c_im;
                    n_d  = n_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            n_q     <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            n_q     <= n_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
            zo_q    <= zo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign iter      = iter_q;
    assign escaped   = esc_q;
    assign z_out     = zo_q;

endmodule

// File: tb/tb_fixcomplex_mandeliter.sv
// Randomized + directed bench for fixcomplex_mandeliter against a plain-integer escape-time model.
module tb_fixcomplex_mandeliter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] c = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  iter;
    logic        escaped;
    logic [31:0] z_out;

    int n_cmp = 0;
    int n_bad = 0;

    fixcomplex_mandeliter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .iter(iter), .escaped(escaped),
        .z_out(z_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint wrap16(input longint x);
        logic [15:0] t;
        t = x[15:0];
        return longint'($signed(t));
    endfunction

    // Escape-time iteration on plain integers, values scaled by 256.
    function automatic void model(input logic [31:0] cv, output int it, output bit esc,
                                  output logic [31:0] zo);
        longint cr, ci, zr, zi, nr, ni;
        logic [15:0] h;
        h  = cv[15:0];  cr = longint'($signed(h));
        h  = cv[31:16]; ci = longint'($signed(h));
        zr = 0; zi = 0; it = 0;
        while (1) begin
            if (zr * zr + zi * zi >= 64'd4 * 256 * 256) begin esc = 1'b1; break; end
            if (it == 255) begin esc = 1'b0; break; end
            nr = wrap16(((zr * zr) >>> 8) - ((zi * zi) >>> 8) + cr);
            ni = wrap16(2 * ((zr * zi) >>> 8) + ci);
            zr = nr; zi = ni; it++;
        end
        zo = {zi[15:0], zr[15:0]};
    endfunction

    // Runs one job from IDLE; hold > 0 keeps out_ready low that many extra cycles
    // while in_valid is waved at the busy engine.
    task automatic run_job(input logic [31:0] cv, input int hold,
                           output int o_it, output bit o_esc, output logic [31:0] o_z);
        int e_it, cyc;
        bit e_esc;
        logic [31:0] e_z;
        model(cv, e_it, e_esc, e_z);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        c = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; c = $urandom;
        cyc = 0;
        while (!out_valid && cyc < 400) begin @(posedge clk); #1; cyc++; end
        chk("latency", 32'(cyc), 32'(e_it + 1));
        chk("iter", 32'(iter), 32'(e_it));
        chk("escaped", 32'(escaped), 32'(e_esc));
        chk("z_out", z_out, e_z);
        o_it = int'(iter); o_esc = escaped; o_z = z_out;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; c = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_iter", 32'(iter), 32'(e_it));
            chk("hold_z", z_out, e_z);
        end
        // Retire with in_valid possibly high: the engine must land in IDLE, not restart.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_ready", 32'(in_ready), 32'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            chk("no_accept_in_done", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int it;
        bit es;
        logic [31:0] zo;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_iter", 32'(iter), 32'd0);
        chk("rst_escaped", 32'(escaped), 32'd0);
        chk("rst_z_out", z_out, 32'd0);

        run_job(32'h0000_0000, 0, it, es, zo);
        chk("c0_iter", 32'(it), 32'd255);
        chk("c0_esc", 32'(es), 32'd0);
        chk("c0_z", zo, 32'd0);

        run_job(32'h0000_0100, 0, it, es, zo);
        chk("c1_iter", 32'(it), 32'd2);
        chk("c1_esc", 32'(es), 32'd1);
        chk("c1_z", zo, 32'h0000_0200);

        run_job(32'h0000_FE00, 0, it, es, zo);
        chk("cm2_iter", 32'(it), 32'd1);
        chk("cm2_esc", 32'(es), 32'd1);
        chk("cm2_z", zo, 32'h0000_FE00);

        run_job(32'h0000_FF00, 0, it, es, zo);
        chk("cm1_iter", 32'(it), 32'd255);
        chk("cm1_esc", 32'(es), 32'd0);

        run_job(32'h0100_0000, 0, it, es, zo);
        chk("ci_iter", 32'(it), 32'd255);
        chk("ci_esc", 32'(es), 32'd0);

        run_job(32'h0000_0300, 10, it, es, zo);
        chk("c3_iter", 32'(it), 32'd1);
        chk("c3_esc", 32'(es), 32'd1);

        // Reset mid-run at n=5 discards the job.
        c = 32'h0000_0000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_iter", 32'(iter), 32'd0);
        run_job(32'h0000_0100, 0, it, es, zo);

        // Random c, mostly in the interesting [-2.5, 2.5) window, some full-range.
        for (int j = 0; j < 40; j++) begin
            logic [15:0] re, im;
            if (j % 4 == 0) begin
                re = 16'($urandom); im = 16'($urandom);
            end else begin
                re = 16'($urandom_range(0, 1279) - 640);
                im = 16'($urandom_range(0, 1279) - 640);
            end
            run_job({im, re}, (j % 5 == 0) ? 3 : 0, it, es, zo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
